// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame receiver and the upstream generator:
// FSM state encoding and parity-mode constants.
package parity_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } rx_state_e;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// XOR reduction of a data word; the same block feeds the upstream parity generator.
module parity_calc #(
  parameter int DATA_W = 3
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              parity_o
);

  assign parity_o = ^data_i;

endmodule

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Optional error counter output enabled by defining PARITY_RX_ERR_CNT_EN.
module parity_frame_rx
  import parity_pkg::*;
#(
  parameter int DATA_W     = 3,
  parameter bit PARITY_ODD = PAR_EVEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
`ifdef PARITY_RX_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              perr_q, perr_d;
  logic              valid_q, valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              xor_w;

  parity_calc #(.DATA_W(DATA_W)) u_parity (
    .data_i   (shift_q),
    .parity_o (xor_w)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    valid_d      = 1'b0;
    data_d       = data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    if (bit_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (!rx_bit) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        S_DATA: begin
          // LSB arrives first, so new bits enter at the top and drift down.
          shift_d = (shift_q >> 1) | (DATA_W'(rx_bit) << (DATA_W - 1));
          if (cnt_q == CNT_LAST) state_d = S_PARITY;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        S_PARITY: begin
          perr_d  = rx_bit ^ xor_w ^ (PARITY_ODD == PAR_ODD);
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d      = S_IDLE;
          valid_d      = 1'b1;
          data_d       = shift_q;
          parity_err_d = perr_q;
          frame_err_d  = ~rx_bit;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);

`ifdef PARITY_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts frames, not error kinds, and sticks at full scale.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (valid_d && (parity_err_d || frame_err_d) && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx (default parameters); covers the
// error counter too when PARITY_RX_ERR_CNT_EN is defined.
module tb_parity_frame_rx;

  localparam int DW   = 3;
  localparam bit PODD = 1'b0;

  logic          clk = 1'b0;
  logic          rst;
  logic          bit_en;
  logic          rx_bit;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;
`ifdef PARITY_RX_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  parity_frame_rx dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .rx_bit     (rx_bit),
    .data_out   (data_out),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
`ifdef PARITY_RX_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          pe;
    logic          fe;
  } exp_t;

  typedef struct {
    logic [DW-1:0] d;
    logic          pbit;
    logic          stopb;
    int            gap;
    logic [DW-1:0] exp_d;
    logic          exp_pe;
    logic          exp_fe;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: expected parity bit is the count of ones mod 2, flipped in odd mode.
  function automatic exp_t model(input logic [DW-1:0] d, input logic pbit, input logic stopb);
    exp_t e;
    int   ones;
    ones = $countones(d);
    e.d  = d;
    e.pe = (pbit != logic'((ones % 2) ^ int'(PODD)));
    e.fe = (stopb == 1'b0);
    return e;
  endfunction

  // Every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && valid !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid=%b, expected 0 (t=%0t)", valid, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_data", 32'(data_out), 32'(e.d));
        chk("sb_parity_err", 32'(parity_err), 32'(e.pe));
        chk("sb_frame_err", 32'(frame_err), 32'(e.fe));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      bit_en = 1'($urandom);
      rx_bit = 1'b1;
      @(posedge clk); #1;
    end
    bit_en = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic stopb,
                            input int gap, input exp_t e);
    logic [DW+2:0] seq;
    seq = {stopb, pbit, d, 1'b0};
    exp_q.push_back(e);
    for (int i = 0; i < DW + 3; i++) begin
      bit_en = 1'b1;
      rx_bit = seq[i];
      @(posedge clk); #1;
      if (i == DW + 2) begin
        chk("valid_after_stop", 32'(valid), 32'd1);
        chk("data_out", 32'(data_out), 32'(e.d));
        chk("parity_err", 32'(parity_err), 32'(e.pe));
        chk("frame_err", 32'(frame_err), 32'(e.fe));
      end else begin
        chk("busy_in_frame", 32'(busy), 32'd1);
        repeat (gap) begin
          bit_en = 1'b0;
          rx_bit = 1'($urandom);
          @(posedge clk); #1;
        end
      end
    end
    bit_en = 1'b0;
    rx_bit = 1'b1;
  endtask

  initial begin
    vec_t vecs[7];
    exp_t e;
    logic [DW-1:0] rd;
    logic          rp, rs;

    vecs[0] = '{d: 3'b101, pbit: 1'b0, stopb: 1'b1, gap: 0, exp_d: 3'b101, exp_pe: 1'b0, exp_fe: 1'b0};
    vecs[1] = '{d: 3'b111, pbit: 1'b0, stopb: 1'b1, gap: 0, exp_d: 3'b111, exp_pe: 1'b1, exp_fe: 1'b0};
    vecs[2] = '{d: 3'b010, pbit: 1'b1, stopb: 1'b0, gap: 0, exp_d: 3'b010, exp_pe: 1'b0, exp_fe: 1'b1};
    vecs[3] = '{d: 3'b101, pbit: 1'b0, stopb: 1'b1, gap: 3, exp_d: 3'b101, exp_pe: 1'b0, exp_fe: 1'b0};
    vecs[4] = '{d: 3'b000, pbit: 1'b1, stopb: 1'b0, gap: 1, exp_d: 3'b000, exp_pe: 1'b1, exp_fe: 1'b1};
    vecs[5] = '{d: 3'b001, pbit: 1'b1, stopb: 1'b1, gap: 0, exp_d: 3'b001, exp_pe: 1'b0, exp_fe: 1'b0};
    vecs[6] = '{d: 3'b110, pbit: 1'b0, stopb: 1'b1, gap: 2, exp_d: 3'b110, exp_pe: 1'b0, exp_fe: 1'b0};

    // Reset has priority over a start bit presented with bit_en.
    rst = 1'b1; bit_en = 1'b1; rx_bit = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0; bit_en = 1'b0; rx_bit = 1'b1;
    idle(2);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 7; i++) begin
      e.d = vecs[i].exp_d; e.pe = vecs[i].exp_pe; e.fe = vecs[i].exp_fe;
      send_frame(vecs[i].d, vecs[i].pbit, vecs[i].stopb, vecs[i].gap, e);
      idle(1);
    end

    // Outputs hold across idle cycles until the next frame completes.
    idle(4);
    chk("hold_data", 32'(data_out), 32'(3'b110));
    chk("hold_parity_err", 32'(parity_err), 32'd0);
    chk("hold_valid", 32'(valid), 32'd0);

    // Back-to-back frames: next start bit lands in the valid cycle.
    send_frame(3'b011, 1'b0, 1'b1, 0, model(3'b011, 1'b0, 1'b1));
    send_frame(3'b100, 1'b0, 1'b0, 0, model(3'b100, 1'b0, 1'b0));
    idle(1);

    // Mid-frame reset after two data bits discards the partial frame.
    bit_en = 1'b1; rx_bit = 1'b0; @(posedge clk); #1;
    rx_bit = 1'b1; @(posedge clk); #1;
    rx_bit = 1'b1; @(posedge clk); #1;
    rst = 1'b1; rx_bit = 1'b0; @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data", 32'(data_out), 32'd0);
    chk("midrst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0; bit_en = 1'b0; rx_bit = 1'b1;
    idle(3);
    send_frame(3'b111, 1'b0, 1'b1, 0, model(3'b111, 1'b0, 1'b1));
    idle(2);

    // Random frames, gaps and idle spacing.
    for (int i = 0; i < 60; i++) begin
      rd = DW'($urandom);
      rp = 1'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rd, rp, rs, $urandom_range(0, 2), model(rd, rp, rs));
      idle($urandom_range(0, 2));
    end

`ifdef PARITY_RX_ERR_CNT_EN
    rst = 1'b1; @(posedge clk); #1;
    rst = 1'b0;
    chk("errcnt_reset", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 260; i++) begin
      rd = DW'($urandom);
      rp = 1'($urandom);
      send_frame(rd, rp, 1'b0, 0, model(rd, rp, 1'b0));
      if (i == 2) chk("errcnt_three", 32'(err_cnt), 32'd3);
    end
    chk("errcnt_saturated", 32'(err_cnt), 32'd255);
    send_frame(3'b101, 1'b0, 1'b1, 0, model(3'b101, 1'b0, 1'b1));
    idle(2);
    chk("errcnt_after_clean", 32'(err_cnt), 32'd255);
`endif

    idle(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
